seg_display_driver: RTL and testbench
=====================================

Name: seg_display_driver

Overview:
Downstream display stage of the 8-bit CPU. It takes register write-back values and shows them on the two 7-segment digits (seg_ten, seg_one) as signed decimal. The value is captured on a strobe and converted by an iterative shift-add-3 (double-dabble) engine. A one-deep latest-wins pending buffer absorbs strobes that arrive mid-conversion. Outputs are registered and update atomically.

Parameters:
BLANK_LEADING_ZERO, 1, 1: tens digit blank when a non-negative value is < 10; 0: show "0".
SEG_ACTIVE_LOW, 1, 1: segment bit low = lit; 0: all segment outputs inverted.

Ports:
clk50  input  1  system clock; all state on rising edge
reset  input  1  synchronous, active-low reset
value_in  input  8  two's-complement value to display
value_valid  input  1  single-cycle strobe; value_in sampled on the same edge
busy  output  1  high while a conversion is in flight (state != IDLE)
updated  output  1  one-cycle pulse on the edge the segment outputs change
seg_ten  output  7  tens digit, bit order {g,f,e,d,c,b,a}
seg_one  output  7  ones digit, bit order {g,f,e,d,c,b,a}

Behaviour:
- Reset (reset==0 at an edge): state=IDLE, pending cleared, busy=0, updated=0, seg_ten=seg_one=BLANK. Reset aborts any conversion. The pending value is discarded and no updated pulse is produced.
- States: IDLE -> ABS -> SHIFT (8 cycles, iteration counter 0..7) -> LATCH -> IDLE, or -> ABS when work remains.
- IDLE: value_valid=1 loads the operand and moves to ABS.
- ABS: sign = bit7; magnitude = sign ? -value : value, computed 8 bits wide; -128 yields magnitude 128. Clear the BCD register {hundreds, tens, ones}.
- SHIFT: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, mag} left by 1. After the 8th cycle, go to LATCH.
- LATCH: register the segment codes and pulse updated=1 on this edge.
- Latency: accept edge E0. Outputs and updated become visible after edge E10, i.e. a fixed 10 cycles from accept to display.
- Display mapping:
  - Positive value, hundreds==0: tens = digit, or BLANK if tens==0 and BLANK_LEADING_ZERO=1; ones = digit.
  - Negative value, hundreds==0 and tens==0: tens = DASH, ones = digit. This covers -1..-9.
  - All other values (100..127, -10..-128): both digits DASH.
- Pending buffer: value_valid while busy stores value_in into pending and sets pending_v. A later strobe overwrites it (latest wins).
- In LATCH, the next state is chosen as follows:
  - value_valid=1 on that edge: go to ABS with value_in; pending_v is cleared.
  - Else if pending_v=1: go to ABS with the pending value; pending_v is cleared.
  - Else: go to IDLE.
- busy is registered and equals (state != IDLE). updated is 0 on every edge except LATCH.
- SEG_ACTIVE_LOW=0: the final outputs are the bitwise inverse of the codes listed below. BLANK becomes 7'h00.
- Active-low codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - DASH=0111111, BLANK=1111111

Decomposition:
- Shared package, disp_pkg: state enum (IDLE, ABS, SHIFT, LATCH), the SEG_* code constants for 0-9, SEG_DASH and SEG_BLANK, and the BCD nibble width.
- One combinational sub-module, seg7_decode: input 4-bit digit plus 2-bit select (digit/dash/blank), output 7-bit active-low code.
- Two instances of seg7_decode, feeding the output registers in LATCH.

Test Plan:
- Reset: hold reset=0 for 3 edges mid-stream -> seg_ten=seg_one=7'b1111111, busy=0, updated=0.
- value_in=8'd42 strobed at E0:
  - busy=1 for 10 cycles.
  - After E10: seg_ten=0011001, seg_one=0100100, with exactly one updated pulse.
- Single digits:
  - 8'd7 -> seg_ten=1111111, seg_one=1111000.
  - 8'hFD (-3) -> seg_ten=0111111, seg_one=0110000.
  - With BLANK_LEADING_ZERO=0, 8'd7 -> seg_ten=1000000.
- Out of range: 8'd100, 8'd127, 8'hF6 (-10) and 8'h80 (-128) each give seg_ten=seg_one=0111111.
- Pending buffer: strobe 11 at E0, 22 at E3, 33 at E5 -> display shows 11 after E10, then 33 after E20. 22 is never shown, and exactly 2 updated pulses occur.
- Reset mid-conversion:
  - Strobe 55, then pull reset low at E5 -> outputs stay blank and no updated pulse occurs.
  - A strobe on the first edge with reset high restarts cleanly with 10-cycle latency.

Source files
------------

// File: rtl/disp_pkg.sv
// +--------------------------------------------------------------------------+
// | disp_pkg - shared FSM states and 7-segment codes for seg_display_driver   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ABS   = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } state_t;

  localparam int BCD_W = 4;

  localparam logic [1:0] SEL_DIGIT = 2'd0;
  localparam logic [1:0] SEL_DASH  = 2'd1;
  localparam logic [1:0] SEL_BLANK = 2'd2;

  // Active-low codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// +--------------------------------------------------------------------------+
// | seg7_decode - BCD digit / dash / blank to active-low 7-segment code       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module seg7_decode
  import disp_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  input  logic [1:0]       sel,
  output logic [6:0]       code
);

  always_comb begin
    code = SEG_BLANK;
    if (sel == SEL_DASH) begin
      code = SEG_DASH;
    end else if (sel == SEL_DIGIT) begin
      case (digit)
        4'd0:    code = SEG_0;
        4'd1:    code = SEG_1;
        4'd2:    code = SEG_2;
        4'd3:    code = SEG_3;
        4'd4:    code = SEG_4;
        4'd5:    code = SEG_5;
        4'd6:    code = SEG_6;
        4'd7:    code = SEG_7;
        4'd8:    code = SEG_8;
        4'd9:    code = SEG_9;
        default: code = SEG_BLANK;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg_display_driver.sv
// +--------------------------------------------------------------------------+
// | seg_display_driver - signed 8-bit value to two 7-segment digits via an    |
// | iterative double-dabble engine with a latest-wins pending buffer. Rev 1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

module seg_display_driver
  import disp_pkg::*;
#(
  parameter bit BLANK_LEADING_ZERO = 1'b1,
  parameter bit SEG_ACTIVE_LOW     = 1'b1
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic [7:0] value_in,
  input  logic       value_valid,
  output logic       busy,
  output logic       updated,
  output logic [6:0] seg_ten,
  output logic [6:0] seg_one
);

  localparam logic [6:0] POL_MASK = SEG_ACTIVE_LOW ? 7'h00 : 7'h7F;
  localparam logic [6:0] BLANK_OUT = SEG_BLANK ^ POL_MASK;

  state_t     state, state_next;
  logic [7:0] operand;
  logic [7:0] pending;
  logic       pending_v;
  logic       sign;
  logic [7:0] mag;
  logic [11:0] bcd;
  logic [2:0] iter;

  logic [BCD_W-1:0] hundreds, tens, ones;
  logic [1:0]       sel_ten, sel_one;
  logic [6:0]       code_ten, code_one;
  logic [7:0]       low_adj;

  assign hundreds = bcd[11:8];
  assign tens     = bcd[7:4];
  assign ones     = bcd[3:0];

  // Hundreds never exceeds 1 for an 8-bit magnitude, so only tens/ones need the +3 correction.
  for (genvar n = 0; n < 2; n++) begin : g_adj
    assign low_adj[n*BCD_W +: BCD_W] = (bcd[n*BCD_W +: BCD_W] >= 4'd5)
                                     ? bcd[n*BCD_W +: BCD_W] + 4'd3
                                     : bcd[n*BCD_W +: BCD_W];
  end

  always_ff @(posedge clk50) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (value_valid) state_next = ABS;
      ABS:     state_next = SHIFT;
      SHIFT:   if (iter == 3'd7) state_next = LATCH;
      LATCH:   state_next = (value_valid || pending_v) ? ABS : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sel_ten = SEL_DASH;
    sel_one = SEL_DASH;
    if (!sign && hundreds == 4'd0) begin
      sel_one = SEL_DIGIT;
      sel_ten = (BLANK_LEADING_ZERO && tens == 4'd0) ? SEL_BLANK : SEL_DIGIT;
    end else if (sign && hundreds == 4'd0 && tens == 4'd0) begin
      sel_one = SEL_DIGIT;
    end
  end

  seg7_decode u_dec_ten (.digit(tens), .sel(sel_ten), .code(code_ten));
  seg7_decode u_dec_one (.digit(ones), .sel(sel_one), .code(code_one));

  always_ff @(posedge clk50) begin
    if (!reset) begin
      pending_v <= 1'b0;
      busy      <= 1'b0;
      updated   <= 1'b0;
      seg_ten   <= BLANK_OUT;
      seg_one   <= BLANK_OUT;
      iter      <= 3'd0;
    end else begin
      busy    <= (state_next != IDLE);
      updated <= (state == LATCH);
      if (value_valid && state != IDLE && state != LATCH) begin
        pending   <= value_in;
        pending_v <= 1'b1;
      end
      case (state)
        IDLE: if (value_valid) operand <= value_in;
        ABS: begin
          sign <= operand[7];
          mag  <= operand[7] ? (~operand + 8'd1) : operand;
          bcd  <= 12'd0;
          iter <= 3'd0;
        end
        SHIFT: begin
          {bcd, mag} <= {bcd[10:8], low_adj, mag, 1'b0};
          iter       <= iter + 3'd1;
        end
        LATCH: begin
          seg_ten   <= code_ten ^ POL_MASK;
          seg_one   <= code_one ^ POL_MASK;
          pending_v <= 1'b0;
          if (value_valid)    operand <= value_in;
          else if (pending_v) operand <= pending;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_display_driver.sv
`default_nettype none

module tb_seg_display_driver;

  logic       clk50 = 1'b0;
  logic       reset;
  logic [7:0] value_in;
  logic       value_valid;
  logic       busy_a, updated_a, busy_b, updated_b;
  logic [6:0] ten_a, one_a, ten_b, one_b;

  int checks = 0;
  int errors = 0;
  int upd_a  = 0;
  int upd_b  = 0;

  always #10 clk50 = ~clk50;

  seg_display_driver dut_a (
    .clk50(clk50), .reset(reset), .value_in(value_in), .value_valid(value_valid),
    .busy(busy_a), .updated(updated_a), .seg_ten(ten_a), .seg_one(one_a)
  );

  seg_display_driver #(.BLANK_LEADING_ZERO(1'b0), .SEG_ACTIVE_LOW(1'b0)) dut_b (
    .clk50(clk50), .reset(reset), .value_in(value_in), .value_valid(value_valid),
    .busy(busy_b), .updated(updated_b), .seg_ten(ten_b), .seg_one(one_b)
  );

  always @(negedge clk50) begin
    if (updated_a === 1'b1) upd_a++;
    if (updated_b === 1'b1) upd_b++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk50);
    #1;
  endtask

  task automatic strobe(input logic [7:0] v);
    @(negedge clk50);
    value_in    = v;
    value_valid = 1'b1;
    @(posedge clk50);
    #1;
    value_valid = 1'b0;
  endtask

  task automatic test_reset();
    int u0;
    reset = 1'b0; value_valid = 1'b0; value_in = 8'd0;
    tick(3);
    checks++; if (ten_a !== 7'b1111111 || one_a !== 7'b1111111) begin errors++;
      $display("FAIL reset_segs: got %b %b expected 1111111 1111111", ten_a, one_a); end
    checks++; if (busy_a !== 1'b0 || updated_a !== 1'b0) begin errors++;
      $display("FAIL reset_flags: got busy=%b updated=%b expected 0 0", busy_a, updated_a); end
    checks++; if (ten_b !== 7'b0000000 || one_b !== 7'b0000000) begin errors++;
      $display("FAIL reset_segs_inv: got %b %b expected 0000000 0000000", ten_b, one_b); end
    reset = 1'b1;
    u0 = upd_a;
    strobe(8'd42);
    tick(4);
    reset = 1'b0;
    tick(3);
    checks++; if (busy_a !== 1'b0 || ten_a !== 7'b1111111 || one_a !== 7'b1111111) begin errors++;
      $display("FAIL reset_midstream: got busy=%b %b %b expected 0 1111111 1111111", busy_a, ten_a, one_a); end
    reset = 1'b1;
    tick(12);
    checks++; if (upd_a != u0 || ten_a !== 7'b1111111) begin errors++;
      $display("FAIL reset_no_update: got pulses=%0d ten=%b expected 0 1111111", upd_a - u0, ten_a); end
  endtask

  task automatic test_42();
    int u0, nb;
    u0 = upd_a; nb = 0;
    strobe(8'd42);
    for (int i = 0; i < 10; i++) begin
      if (busy_a === 1'b1) nb++;
      tick(1);
    end
    checks++; if (nb != 10 || busy_a !== 1'b0) begin errors++;
      $display("FAIL busy_42: got %0d busy cycles, busy_now=%b expected 10 0", nb, busy_a); end
    checks++; if (updated_a !== 1'b1 || upd_a != u0) begin errors++;
      $display("FAIL latency_42: got updated=%b early=%0d expected 1 0", updated_a, upd_a - u0); end
    checks++; if (ten_a !== 7'b0011001 || one_a !== 7'b0100100) begin errors++;
      $display("FAIL segs_42: got %b %b expected 0011001 0100100", ten_a, one_a); end
    checks++; if (ten_b !== 7'b1100110 || one_b !== 7'b1011011) begin errors++;
      $display("FAIL segs_42_inv: got %b %b expected 1100110 1011011", ten_b, one_b); end
    tick(3);
    checks++; if (upd_a - u0 != 1 || upd_b - u0 != 1) begin errors++;
      $display("FAIL pulses_42: got %0d/%0d expected 1/1", upd_a - u0, upd_b - u0); end
  endtask

  task automatic test_value(input logic [7:0] v, input string name,
                            input logic [6:0] et, input logic [6:0] eo,
                            input logic [6:0] etb, input logic [6:0] eob);
    strobe(v);
    tick(9);
    checks++; if (updated_a !== 1'b0) begin errors++;
      $display("FAIL %s_early: got updated=%b expected 0", name, updated_a); end
    tick(1);
    checks++; if (ten_a !== et || one_a !== eo || updated_a !== 1'b1) begin errors++;
      $display("FAIL %s: got %b %b upd=%b expected %b %b 1", name, ten_a, one_a, updated_a, et, eo); end
    checks++; if (ten_b !== etb || one_b !== eob) begin errors++;
      $display("FAIL %s_inv: got %b %b expected %b %b", name, ten_b, one_b, etb, eob); end
    tick(2);
  endtask

  task automatic test_pending();
    int u0;
    u0 = upd_a;
    strobe(8'd11);
    tick(2);
    value_in = 8'd22; value_valid = 1'b1;
    tick(1);
    value_valid = 1'b0;
    tick(1);
    value_in = 8'd33; value_valid = 1'b1;
    tick(1);
    value_valid = 1'b0;
    tick(5);
    checks++; if (ten_a !== 7'b1111001 || one_a !== 7'b1111001 || updated_a !== 1'b1) begin errors++;
      $display("FAIL pending_first: got %b %b upd=%b expected 1111001 1111001 1", ten_a, one_a, updated_a); end
    checks++; if (busy_a !== 1'b1) begin errors++;
      $display("FAIL pending_busy: got %b expected 1", busy_a); end
    tick(9);
    checks++; if (ten_a !== 7'b1111001 || upd_a - u0 != 1) begin errors++;
      $display("FAIL pending_hold: got ten=%b pulses=%0d expected 1111001 1", ten_a, upd_a - u0); end
    tick(1);
    checks++; if (ten_a !== 7'b0110000 || one_a !== 7'b0110000 || updated_a !== 1'b1) begin errors++;
      $display("FAIL pending_latest: got %b %b upd=%b expected 0110000 0110000 1", ten_a, one_a, updated_a); end
    tick(3);
    checks++; if (upd_a - u0 != 2 || busy_a !== 1'b0) begin errors++;
      $display("FAIL pending_pulses: got %0d busy=%b expected 2 0", upd_a - u0, busy_a); end
  endtask

  task automatic test_back_to_back();
    strobe(8'd5);
    tick(9);
    value_in = 8'd6; value_valid = 1'b1;
    tick(1);
    value_valid = 1'b0;
    checks++; if (ten_a !== 7'b1111111 || one_a !== 7'b0010010 || busy_a !== 1'b1) begin errors++;
      $display("FAIL b2b_first: got %b %b busy=%b expected 1111111 0010010 1", ten_a, one_a, busy_a); end
    tick(10);
    checks++; if (one_a !== 7'b0000010 || updated_a !== 1'b1 || one_b !== 7'b1111101) begin errors++;
      $display("FAIL b2b_second: got %b upd=%b inv=%b expected 0000010 1 1111101", one_a, updated_a, one_b); end
    tick(2);
  endtask

  task automatic test_reset_mid();
    int u0;
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    u0 = upd_a;
    strobe(8'd55);
    tick(4);
    reset = 1'b0;
    tick(1);
    checks++; if (busy_a !== 1'b0) begin errors++;
      $display("FAIL rmid_busy: got %b expected 0", busy_a); end
    tick(2);
    reset = 1'b1; value_in = 8'd55; value_valid = 1'b1;
    tick(1);
    value_valid = 1'b0;
    checks++; if (busy_a !== 1'b1 || ten_a !== 7'b1111111 || one_a !== 7'b1111111 || upd_a != u0) begin errors++;
      $display("FAIL rmid_restart: got busy=%b %b %b pulses=%0d expected 1 1111111 1111111 0", busy_a, ten_a, one_a, upd_a - u0); end
    tick(9);
    checks++; if (updated_a !== 1'b0 || one_a !== 7'b1111111) begin errors++;
      $display("FAIL rmid_early: got upd=%b one=%b expected 0 1111111", updated_a, one_a); end
    tick(1);
    checks++; if (ten_a !== 7'b0010010 || one_a !== 7'b0010010 || updated_a !== 1'b1) begin errors++;
      $display("FAIL rmid_55: got %b %b upd=%b expected 0010010 0010010 1", ten_a, one_a, updated_a); end
    checks++; if (ten_b !== 7'b1101101 || one_b !== 7'b1101101) begin errors++;
      $display("FAIL rmid_55_inv: got %b %b expected 1101101 1101101", ten_b, one_b); end
    tick(2);
  endtask

  initial begin
    test_reset();
    test_42();
    test_value(8'd7,   "val_7",   7'b1111111, 7'b1111000, 7'b0111111, 7'b0000111);
    test_value(8'hFD,  "val_m3",  7'b0111111, 7'b0110000, 7'b1000000, 7'b1001111);
    test_value(8'd0,   "val_0",   7'b1111111, 7'b1000000, 7'b0111111, 7'b0111111);
    test_value(8'd10,  "val_10",  7'b1111001, 7'b1000000, 7'b0000110, 7'b0111111);
    test_value(8'd99,  "val_99",  7'b0010000, 7'b0010000, 7'b1101111, 7'b1101111);
    test_value(8'hF7,  "val_m9",  7'b0111111, 7'b0010000, 7'b1000000, 7'b1101111);
    test_value(8'd100, "val_100", 7'b0111111, 7'b0111111, 7'b1000000, 7'b1000000);
    test_value(8'd127, "val_127", 7'b0111111, 7'b0111111, 7'b1000000, 7'b1000000);
    test_value(8'hF6,  "val_m10", 7'b0111111, 7'b0111111, 7'b1000000, 7'b1000000);
    test_value(8'h80,  "val_m128",7'b0111111, 7'b0111111, 7'b1000000, 7'b1000000);
    test_pending();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
